fc_sequencer: RTL and testbench

Time-multiplexed controller for the fully-connected layer. It computes Z[j] = sat(sum_i W[j][i]*X[i] + B[j]) for every output neuron j using one shared multiply-accumulate unit instead of a combinational array. It sequences input capture, weight/bias memory reads, accumulation, and result streaming. It sits between the previous layer's output stream and the next layer's input stream, and reads external weight and bias ROMs.

---
 rtl/fc_sequencer.sv | 121 ++++++++++++
 tb/tb_fc_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fc_sequencer.sv
// fc_sequencer: fully-connected layer Z[j] = sat(sum_i W[j][i]*X[i] + B[j]) computed with one shared MAC.
module fc_sequencer #(
  parameter int WORD_SIZE = 16,
  parameter int IP_LAYER_SIZE = 10,
  parameter int OP_LAYER_SIZE = 5,
  parameter int FRAC_BITS = 8,
  localparam int AW = (OP_LAYER_SIZE * IP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE * IP_LAYER_SIZE) : 1,
  localparam int BW = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  input  logic [WORD_SIZE-1:0] x_data_i,
  output logic                 w_en_o,
  output logic [AW-1:0]        w_addr_o,
  input  logic [WORD_SIZE-1:0] w_data_i,
  output logic                 b_en_o,
  output logic [BW-1:0]        b_addr_o,
  input  logic [WORD_SIZE-1:0] b_data_i,
  output logic                 z_valid_o,
  input  logic                 z_ready_i,
  output logic [WORD_SIZE-1:0] z_data_o,
  output logic [BW-1:0]        z_index_o
);
  localparam int IW = $clog2(IP_LAYER_SIZE + 1);
  localparam int ACC_W = 2 * WORD_SIZE + $clog2(IP_LAYER_SIZE) + 1;
  localparam logic [IW-1:0] I_END = IW'(IP_LAYER_SIZE);
  localparam logic [IW-1:0] I_LAST = IW'(IP_LAYER_SIZE - 1);
  localparam logic [BW-1:0] J_LAST = BW'(OP_LAYER_SIZE - 1);
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'((64'sd1 <<< (WORD_SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Z_MIN = -Z_MAX - ACC_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD_X, MAC, OUT, DONE} state_t;

  state_t state_q, state_d;
  logic signed [WORD_SIZE-1:0] x_buf [IP_LAYER_SIZE];
  logic [IW-1:0] i_q, i_d, im1;
  logic [BW-1:0] j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum, shd;
  logic signed [WORD_SIZE-1:0] bias_q, bias_d, z_q, z_d;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic x_we;

  assign im1 = i_q - IW'(1);
  assign prod = x_buf[im1] * $signed(w_data_i);

  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    acc_d = acc_q;
    bias_d = bias_q;
    x_we = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD_X;
        i_d = '0;
        j_d = '0;
      end
      LOAD_X: if (x_valid_i) begin
        x_we = 1'b1;
        i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
        state_d = (i_q == I_LAST) ? MAC : LOAD_X;
      end
      MAC: begin
        acc_d = (i_q == '0) ? '0 : acc_q + ACC_W'(prod);
        bias_d = (i_q == IW'(1)) ? $signed(b_data_i) : bias_q;
        i_d = (i_q == I_END) ? i_q : i_q + IW'(1);
        state_d = (i_q == I_END) ? OUT : MAC;
      end
      OUT: if (z_ready_i) begin
        i_d = '0;
        j_d = (j_q == J_LAST) ? j_q : j_q + BW'(1);
        state_d = (j_q == J_LAST) ? DONE : MAC;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // bias_d already holds b_data on the final cycle when IP_LAYER_SIZE is 1
    sum = acc_d + (ACC_W'(bias_d) <<< FRAC_BITS);
    shd = sum >>> FRAC_BITS;
    z_d = (state_q != MAC || i_q != I_END) ? z_q :
          (shd > Z_MAX) ? WORD_SIZE'(Z_MAX) :
          (shd < Z_MIN) ? WORD_SIZE'(Z_MIN) : WORD_SIZE'(shd);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      bias_q <= '0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      acc_q <= acc_d;
      bias_q <= bias_d;
      z_q <= z_d;
    end
  end

  always_ff @(posedge clk_i) if (x_we) x_buf[i_q] <= x_data_i;

  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign x_ready_o = state_q == LOAD_X;
  assign w_en_o = (state_q == MAC) && (i_q != I_END);
  assign w_addr_o = w_en_o ? AW'(j_q) * AW'(IP_LAYER_SIZE) + AW'(i_q) : '0;
  assign b_en_o = (state_q == MAC) && (i_q == '0);
  assign b_addr_o = b_en_o ? j_q : '0;
  assign z_valid_o = state_q == OUT;
  assign z_data_o = z_valid_o ? z_q : '0;
  assign z_index_o = z_valid_o ? j_q : '0;
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: directed vectors for fc_sequencer with ROM models and hand-computed results.
module tb_fc_sequencer;
  localparam int IP = 10;
  localparam int OP = 5;

  logic clk = 0;
  logic reset = 0;
  logic start = 0;
  logic busy, done, x_valid, x_ready, w_en, b_en, z_valid, z_ready;
  logic [15:0] x_data, w_data, b_data, z_data;
  logic [5:0] w_addr;
  logic [2:0] b_addr, z_index;

  logic [15:0] xv [IP];
  logic [15:0] w_mem [64];
  logic [15:0] b_mem [8];
  logic [15:0] res_d [8];
  logic [2:0] res_i [8];
  logic [15:0] exp_z;
  int cyc = 0, t0 = 0, n_res, n_done, done_rel, busy_first, busy_last;
  int n_chk = 0, n_fail = 0;
  int stall_cnt = 0;
  logic stall_en = 0, active = 0;

  fc_sequencer dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(busy), .done_o(done),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
    .w_en_o(w_en), .w_addr_o(w_addr), .w_data_i(w_data),
    .b_en_o(b_en), .b_addr_o(b_addr), .b_data_i(b_data),
    .z_valid_o(z_valid), .z_ready_i(z_ready), .z_data_o(z_data), .z_index_o(z_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_en) w_data <= w_mem[w_addr];
    if (b_en) b_data <= b_mem[b_addr];
  end

  assign z_ready = !(stall_en && z_valid && z_index == 3'd2 && stall_cnt < 3);
  always @(posedge clk) stall_cnt <= !stall_en ? 0 : (z_valid && !z_ready) ? stall_cnt + 1 : stall_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (active) begin
    int rel;
    rel = cyc - t0;
    if (busy) begin
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (done) begin
      n_done++;
      done_rel = rel;
    end
    if (z_valid && !z_ready) begin
      check("stall_data", {16'd0, z_data}, {16'd0, exp_z});
      check("stall_idx", {29'd0, z_index}, 32'd2);
      check("stall_wen", {31'd0, w_en}, 32'd0);
    end
    if (z_valid && z_ready && n_res < 8) begin
      res_d[n_res] = z_data;
      res_i[n_res] = z_index;
      n_res++;
    end
  end

  task automatic set_data(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < IP; k++) xv[k] = x;
    for (int k = 0; k < 64; k++) w_mem[k] = w;
    for (int k = 0; k < 8; k++) b_mem[k] = b;
  endtask

  task automatic run(input bit gap, input bit stall, input bit mstart, input int exp_done, input logic [15:0] ez);
    int k, c;
    n_res = 0; n_done = 0; done_rel = -1; busy_first = -1; busy_last = -1;
    exp_z = ez;
    stall_en = stall;
    @(posedge clk); #1;
    start = 1; t0 = cyc; active = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0; c = 1;
    while (k < IP && c < 100) begin
      x_valid = gap ? c[0] : 1'b1;
      x_data = xv[k];
      @(negedge clk);
      if (x_valid && x_ready) k++;
      @(posedge clk); #1;
      c++;
    end
    x_valid = 0;
    if (mstart) begin
      repeat (5) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    c = 0;
    while (n_done == 0 && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (4) @(posedge clk);
    #1 active = 0;
    check("stall_cycles", stall_cnt, stall ? 32'd3 : 32'd0);
    stall_en = 0;
    check("done_cycle", done_rel, exp_done);
    check("done_count", n_done, 32'd1);
    check("result_count", n_res, OP);
    for (int j = 0; j < OP; j++) begin
      check("z_index", {29'd0, res_i[j]}, j);
      check("z_data", {16'd0, res_d[j]}, {16'd0, ez});
    end
    check("busy_first", busy_first, 32'd1);
    check("busy_last", busy_last, exp_done);
  endtask

  initial begin
    int c;
    x_valid = 0;
    x_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, x_ready, w_en, b_en, z_valid, w_addr, b_addr, z_index, z_data}, 32'd0);
    reset = 1;

    set_data(16'h0100, 16'h0100, 16'h0000);
    run(0, 0, 0, 71, 16'h0A00);

    set_data(16'h0100, 16'hFF00, 16'h0200);
    run(0, 0, 0, 71, 16'hF800);

    set_data(16'h0000, 16'h0000, 16'h0000);
    xv[0] = 16'h0001;
    for (int j = 0; j < OP; j++) w_mem[j * IP] = 16'hFF80;
    run(0, 0, 0, 71, 16'hFFFF);

    set_data(16'h7FFF, 16'h7FFF, 16'h0000);
    run(0, 0, 0, 71, 16'h7FFF);
    set_data(16'h7FFF, 16'h8000, 16'h0000);
    run(0, 0, 0, 71, 16'h8000);

    set_data(16'h0100, 16'h0100, 16'h0000);
    run(0, 1, 0, 74, 16'h0A00);
    run(1, 0, 1, 71 + IP - 1, 16'h0A00);

    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    x_valid = 1;
    x_data = 16'h0100;
    c = 0;
    while (!(w_en && w_addr == 6'd32) && c < 200) begin
      @(negedge clk);
      c++;
    end
    x_valid = 0;
    check("reset_reach_mac3", {31'd0, c < 200}, 32'd1);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    check("midrun_reset", {28'd0, busy, z_valid, w_en, done}, 32'd0);
    reset = 1;
    run(0, 0, 0, 71, 16'h0A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
